// File: rtl/network_sequencer_if.sv
// Host/NETWORK-facing bus bundle for network_sequencer.
// slave = sequencer view; master = environment (host + NETWORK) view.
interface network_sequencer_if #(
  parameter int FP_WIDTH   = 8,
  parameter int NUM_INPUTS = 9,
  parameter int HL_NEURONS = 6,
  parameter int OL_NEURONS = 3,
  parameter int CLASS_W    = 2,
  parameter int ADDR_W     = 7
);
  logic                                            cfg_we;
  logic [ADDR_W-1:0]                               cfg_addr;
  logic [FP_WIDTH-1:0]                             cfg_data;
  logic                                            cfg_err;
  logic [NUM_INPUTS*FP_WIDTH-1:0]                  in_values;
  logic                                            in_valid;
  logic                                            in_ready;
  logic [OL_NEURONS*FP_WIDTH-1:0]                  res_values;
  logic [CLASS_W-1:0]                              res_class;
  logic                                            res_timeout;
  logic                                            res_valid;
  logic                                            res_ready;
  logic                                            busy;
  logic [NUM_INPUTS*FP_WIDTH-1:0]                  net_values_in;
  logic                                            net_valid_in;
  logic [HL_NEURONS*NUM_INPUTS*FP_WIDTH-1:0]       net_hl_weights;
  logic [HL_NEURONS*FP_WIDTH-1:0]                  net_hl_bias;
  logic [OL_NEURONS*HL_NEURONS*FP_WIDTH-1:0]       net_ol_weights;
  logic [OL_NEURONS*FP_WIDTH-1:0]                  net_ol_bias;
  logic [OL_NEURONS*FP_WIDTH-1:0]                  net_values_out;
  logic                                            net_valid_out;

  modport master (
    output cfg_we, cfg_addr, cfg_data, in_values, in_valid, res_ready,
           net_values_out, net_valid_out,
    input  cfg_err, in_ready, res_values, res_class, res_timeout, res_valid, busy,
           net_values_in, net_valid_in, net_hl_weights, net_hl_bias,
           net_ol_weights, net_ol_bias
  );

  modport slave (
    input  cfg_we, cfg_addr, cfg_data, in_values, in_valid, res_ready,
           net_values_out, net_valid_out,
    output cfg_err, in_ready, res_values, res_class, res_timeout, res_valid, busy,
           net_values_in, net_valid_in, net_hl_weights, net_hl_bias,
           net_ol_weights, net_ol_bias
  );
endinterface

// File: rtl/network_sequencer.sv
// Config register file + launch/collect sequencer for the vowel-recognition NETWORK.
// Optional WAIT timeout enabled by defining NETWORK_SEQ_TIMEOUT_EN.
module network_sequencer #(
  parameter int FP_WIDTH       = 8,
  parameter int FP_FRAC        = 5,
  parameter int NUM_INPUTS     = 9,
  parameter int HL_NEURONS     = 6,
  parameter int OL_NEURONS     = 3,
  parameter int CLASS_W        = 2,
  parameter int ADDR_W         = 7,
  parameter int TIMEOUT_CYCLES = 64
) (
  input logic                 clk_i,
  input logic                 rst_ni,
  network_sequencer_if.slave  bus
);
  localparam int HLW_N     = HL_NEURONS * NUM_INPUTS;
  localparam int HLB_OFF   = HLW_N;
  localparam int OLW_OFF   = HLB_OFF + HL_NEURONS;
  localparam int OLW_N     = OL_NEURONS * HL_NEURONS;
  localparam int OLB_OFF   = OLW_OFF + OLW_N;
  localparam int NUM_WORDS = OLB_OFF + OL_NEURONS;

  typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_WAIT, S_DONE} state_e;

  state_e                                state_q, state_d;
  logic [NUM_WORDS-1:0][FP_WIDTH-1:0]    cfg_q;
  logic [NUM_INPUTS*FP_WIDTH-1:0]        net_in_q;
  logic                                  net_valid_q;
  logic [OL_NEURONS*FP_WIDTH-1:0]        res_values_q;
  logic [CLASS_W-1:0]                    res_class_q;
  logic                                  res_valid_q;
  logic                                  cfg_err_q;

  logic in_ready, in_fire, cfg_ok, capture, expire, res_fire, tmo_hit;

  // Strict '>' keeps the earliest index on ties.
  function automatic logic [CLASS_W-1:0] argmax(input logic [OL_NEURONS*FP_WIDTH-1:0] v);
    logic [CLASS_W-1:0]         best;
    logic signed [FP_WIDTH-1:0] bv;
    best = '0;
    bv   = $signed(v[0 +: FP_WIDTH]);
    for (int i = 1; i < OL_NEURONS; i++) begin
      if ($signed(v[i*FP_WIDTH +: FP_WIDTH]) > bv) begin
        best = CLASS_W'(i);
        bv   = $signed(v[i*FP_WIDTH +: FP_WIDTH]);
      end
    end
    return best;
  endfunction

  assign in_ready = rst_ni & (state_q == S_IDLE) & ~bus.cfg_we;
  assign in_fire  = bus.in_valid & in_ready;
  assign cfg_ok   = bus.cfg_we & (state_q == S_IDLE) & (bus.cfg_addr < ADDR_W'(NUM_WORDS));
  assign capture  = (state_q == S_WAIT) & bus.net_valid_out;
  assign expire   = (state_q == S_WAIT) & ~bus.net_valid_out & tmo_hit;
  assign res_fire = res_valid_q & bus.res_ready;

`ifdef NETWORK_SEQ_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES) + 1;
  logic [TMO_W-1:0] tmo_q;
  logic             res_timeout_q;

  assign tmo_hit = (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1));

  // Cleared in LAUNCH so WAIT always starts counting from zero.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tmo_q         <= '0;
      res_timeout_q <= 1'b0;
    end else begin
      if (state_q == S_LAUNCH)    tmo_q <= '0;
      else if (state_q == S_WAIT) tmo_q <= tmo_q + 1'b1;
      if (capture)     res_timeout_q <= 1'b0;
      else if (expire) res_timeout_q <= 1'b1;
    end
  end

  assign bus.res_timeout = res_timeout_q;
`else
  assign tmo_hit         = 1'b0;
  assign bus.res_timeout = 1'b0;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:   if (in_fire)              state_d = S_LAUNCH;
      S_LAUNCH:                           state_d = S_WAIT;
      S_WAIT:   if (capture || expire)    state_d = S_DONE;
      S_DONE:   if (res_fire)             state_d = S_IDLE;
      default:                            state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cfg_q        <= '0;
      cfg_err_q    <= 1'b0;
      net_in_q     <= '0;
      net_valid_q  <= 1'b0;
      res_values_q <= '0;
      res_class_q  <= '0;
      res_valid_q  <= 1'b0;
    end else begin
      cfg_err_q   <= bus.cfg_we & ~cfg_ok;
      if (cfg_ok) cfg_q[bus.cfg_addr] <= bus.cfg_data;
      net_valid_q <= in_fire;
      if (in_fire) net_in_q <= bus.in_values;
      if (capture) begin
        res_values_q <= bus.net_values_out;
        res_class_q  <= argmax(bus.net_values_out);
        res_valid_q  <= 1'b1;
      end else if (expire) begin
        res_values_q <= '0;
        res_class_q  <= '0;
        res_valid_q  <= 1'b1;
      end else if (res_fire) begin
        res_valid_q  <= 1'b0;
      end
    end
  end

  assign bus.in_ready       = in_ready;
  assign bus.cfg_err        = cfg_err_q;
  assign bus.busy           = (state_q != S_IDLE);
  assign bus.net_values_in  = net_in_q;
  assign bus.net_valid_in   = net_valid_q;
  assign bus.res_values     = res_values_q;
  assign bus.res_class      = res_class_q;
  assign bus.res_valid      = res_valid_q;
  assign bus.net_hl_weights = cfg_q[HLW_N-1:0];
  assign bus.net_hl_bias    = cfg_q[HLB_OFF +: HL_NEURONS];
  assign bus.net_ol_weights = cfg_q[OLW_OFF +: OLW_N];
  assign bus.net_ol_bias    = cfg_q[OLB_OFF +: OL_NEURONS];
endmodule
